// File: rtl/pdecoder_pkg.sv
// Shared widths and helpers for the 8-to-3 priority decoder.
package pdecoder_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 3;

  // Clearing the lowest set bit leaves something behind only when two or more bits were set.
  function automatic logic at_least_two(input logic [IN_W-1:0] d);
    logic [IN_W-1:0] one;
    one = {{(IN_W-1){1'b0}}, 1'b1};
    return (d & (d - one)) != '0;
  endfunction

endpackage

// File: rtl/pencoder_core.sv
// Combinational priority encoder: winning index, any-request and multi-request flags.
module pencoder_core
  import pdecoder_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic [IN_W-1:0]  d_i,
  output logic [OUT_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  // The last matching bit in scan order wins, so scan towards the favoured end.
  always_comb begin
    // NOTE: default assigned first so every path drives idx_o and no latch is inferred.
    idx_o = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < IN_W; i++) begin
        if (d_i[i]) idx_o = OUT_W'(i);
      end
    end else begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (d_i[i]) idx_o = OUT_W'(i);
      end
    end
  end

  assign any_o   = |d_i;
  assign multi_o = at_least_two(d_i);

endmodule

// File: rtl/pdecoder_8to3.sv
// 8-to-3 priority decoder: pencoder_core followed by an enabled, synchronously reset output register.
module pdecoder_8to3
  import pdecoder_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  D,
  output logic [OUT_W-1:0] Y,
  output logic             V,
  output logic             M
);

  logic [OUT_W-1:0] y_q, y_d;
  logic             v_q, v_d;
  logic             m_q, m_d;
  logic [OUT_W-1:0] core_idx;
  logic             core_any;
  logic             core_multi;

  pencoder_core #(
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .d_i     (D),
    .idx_o   (core_idx),
    .any_o   (core_any),
    .multi_o (core_multi)
  );

  always_comb begin
    y_d = y_q;
    v_d = v_q;
    m_d = m_q;
    if (en) begin
      y_d = core_idx;
      v_d = core_any;
      m_d = core_multi;
    end
  end

  // Reset is checked before enable so it clears the outputs even while en is low.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      y_q <= '0;
      v_q <= 1'b0;
      m_q <= 1'b0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
      m_q <= m_d;
    end
  end

  assign Y = y_q;
  assign V = v_q;
  assign M = m_q;

endmodule

// File: tb/tb_pdecoder_8to3.sv
// Directed and random checks of pdecoder_8to3 for both priority directions against a behavioural model.
module tb_pdecoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] D;
  logic [2:0] y_hi, y_lo;
  logic       v_hi, v_lo, m_hi, m_lo;

  int total = 0;
  int bad   = 0;

  // Expected registered outputs for the MSB-first and LSB-first instances.
  logic [2:0] e_y_hi, e_y_lo;
  logic       e_v, e_m;

  always #5 clk = ~clk;

  pdecoder_8to3 #(.MSB_FIRST(1)) dut_hi (
    .clk (clk), .rst (rst), .en (en), .D (D),
    .Y (y_hi), .V (v_hi), .M (m_hi)
  );

  pdecoder_8to3 #(.MSB_FIRST(0)) dut_lo (
    .clk (clk), .rst (rst), .en (en), .D (D),
    .Y (y_lo), .V (v_lo), .M (m_lo)
  );

  function automatic int highest_set(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) if (d[i]) return i;
    return 0;
  endfunction

  function automatic int lowest_set(input logic [7:0] d);
    for (int i = 0; i < 8; i++) if (d[i]) return i;
    return 0;
  endfunction

  function automatic int popcount(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs, let the edge pass, then advance the model.
  task automatic apply(input logic r, input logic e, input logic [7:0] d);
    @(negedge clk);
    rst = r;
    en  = e;
    D   = d;
    @(posedge clk);
    #1;
    if (r) begin
      e_y_hi = 3'd0;
      e_y_lo = 3'd0;
      e_v    = 1'b0;
      e_m    = 1'b0;
    end else if (e) begin
      e_y_hi = 3'(highest_set(d));
      e_y_lo = 3'(lowest_set(d));
      e_v    = popcount(d) >= 1;
      e_m    = popcount(d) >= 2;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".hi"}, {3'b0, y_hi, v_hi, m_hi}, {3'b0, e_y_hi, e_v, e_m});
    check({tag, ".lo"}, {3'b0, y_lo, v_lo, m_lo}, {3'b0, e_y_lo, e_v, e_m});
  endtask

  initial begin
    logic [7:0] onehot;
    logic [7:0] rd;
    logic       re;
    rst = 1'b1;
    en  = 1'b0;
    D   = 8'h00;

    // Reset state, with en low.
    apply(1'b1, 1'b0, 8'h00);
    check("reset.hi", {3'b0, y_hi, v_hi, m_hi}, 8'h00);
    check("reset.lo", {3'b0, y_lo, v_lo, m_lo}, 8'h00);

    // One-hot walk: both directions report the set bit, valid, no multi.
    for (int i = 0; i < 8; i++) begin
      onehot = 8'h01 << i;
      apply(1'b0, 1'b1, onehot);
      check($sformatf("onehot%0d.hi", i), {3'b0, y_hi, v_hi, m_hi}, {3'b0, 3'(i), 2'b10});
      check($sformatf("onehot%0d.lo", i), {3'b0, y_lo, v_lo, m_lo}, {3'b0, 3'(i), 2'b10});
    end

    // Mixed pattern: highest bit 7, lowest bit 1.
    apply(1'b0, 1'b1, 8'b1010_0110);
    check("mixed.hi", {3'b0, y_hi, v_hi, m_hi}, {3'b0, 3'd7, 2'b11});
    check("mixed.lo", {3'b0, y_lo, v_lo, m_lo}, {3'b0, 3'd1, 2'b11});

    // Empty request after 8'h80 clears everything.
    apply(1'b0, 1'b1, 8'h80);
    apply(1'b0, 1'b1, 8'h00);
    check("zero.hi", {3'b0, y_hi, v_hi, m_hi}, 8'h00);
    check("zero.lo", {3'b0, y_lo, v_lo, m_lo}, 8'h00);

    // Hold while en is low.
    apply(1'b0, 1'b1, 8'h10);
    check("load.hi", {3'b0, y_hi, v_hi, m_hi}, {3'b0, 3'd4, 2'b10});
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 8'h02);
      check($sformatf("hold%0d.hi", i), {3'b0, y_hi, v_hi, m_hi}, {3'b0, 3'd4, 2'b10});
      check($sformatf("hold%0d.lo", i), {3'b0, y_lo, v_lo, m_lo}, {3'b0, 3'd4, 2'b10});
    end

    // Reset wins over en with all requests active, then the first sample follows.
    apply(1'b0, 1'b1, 8'h0C);
    apply(1'b1, 1'b1, 8'hFF);
    check("rst_ff.hi", {3'b0, y_hi, v_hi, m_hi}, 8'h00);
    check("rst_ff.lo", {3'b0, y_lo, v_lo, m_lo}, 8'h00);
    apply(1'b0, 1'b1, 8'hFF);
    check("post_rst.hi", {3'b0, y_hi, v_hi, m_hi}, {3'b0, 3'd7, 2'b11});
    check("post_rst.lo", {3'b0, y_lo, v_lo, m_lo}, {3'b0, 3'd0, 2'b11});

    // Reset with en low also clears.
    apply(1'b1, 1'b0, 8'h55);
    check("rst_en0.hi", {3'b0, y_hi, v_hi, m_hi}, 8'h00);

    // Random requests with random enable and rare reset.
    for (int n = 0; n < 1200; n++) begin
      rd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rd = 8'h01 << $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) rd = 8'h00;
      re = $urandom_range(0, 3) != 0;
      apply($urandom_range(0, 63) == 0, re, rd);
      check_model($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
